// File: rtl/wired_div_pkg.sv
// Shared types and helpers for the wired divider arbiter.
//   div_op_t    : op encoding, bit0 = signed, bit1 = return remainder
//   div_state_t : arbiter sequencing states
//   div_step    : one radix-2 restoring-division iteration on magnitudes
package wired_div_pkg;

  typedef enum logic [1:0] {
    DIVU = 2'b00,
    DIV  = 2'b01,
    MODU = 2'b10,
    MOD  = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } div_state_t;

  localparam int unsigned DIV_CYCLES_DEF = 32;

  // Shift the next dividend bit into the partial remainder and subtract the
  // divisor when it fits. Returns {remainder, quotient}.
  function automatic logic [63:0] div_step(input logic [31:0] rem,
                                           input logic [31:0] quo,
                                           input logic [31:0] d);
    logic [32:0] sh;
    sh = {rem, quo[31]};
    if (sh >= {1'b0, d}) begin
      div_step = {32'(sh - {1'b0, d}), quo[30:0], 1'b1};
    end else begin
      div_step = {sh[31:0], quo[30:0], 1'b0};
    end
  endfunction

endpackage

// File: rtl/wired_div_simp.sv
// Fixed-latency iterative 32-bit divider core (radix-2, restoring).
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   i_start : load operands and perform the first iteration
//   i_sign  : treat operands as two's-complement
//   i_a/i_b : dividend / divisor (divisor must be non-zero)
//   o_quo   : quotient, valid DIV_CYCLES_DEF edges after the start edge
//   o_rem   : remainder, sign follows the dividend
// The core does not report completion; the caller counts iterations.
module wired_div_simp
  import wired_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_sign,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);

  localparam int unsigned CW = $clog2(DIV_CYCLES_DEF);

  logic [31:0]   r_rem;
  logic [31:0]   r_quo;
  logic [31:0]   r_div;
  logic          r_neg_q;
  logic          r_neg_r;
  logic [CW-1:0] r_cnt;

  logic          w_a_neg;
  logic          w_b_neg;
  logic [31:0]   w_abs_a;
  logic [31:0]   w_abs_b;

  assign w_a_neg = i_sign & i_a[31];
  assign w_b_neg = i_sign & i_b[31];
  // Magnitude of 0x80000000 is 0x80000000 as an unsigned value, which keeps
  // the overflow case (MIN / -1) well defined without a special path.
  assign w_abs_a = w_a_neg ? -i_a : i_a;
  assign w_abs_b = w_b_neg ? -i_b : i_b;

  // The start edge already performs iteration one, so the remaining
  // DIV_CYCLES_DEF-1 iterations run while r_cnt counts down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
    end else if (i_start) begin
      {r_rem, r_quo} <= div_step(32'd0, w_abs_a, w_abs_b);
      r_div          <= w_abs_b;
      r_neg_q        <= w_a_neg ^ w_b_neg;
      r_neg_r        <= w_a_neg;
      r_cnt          <= CW'(DIV_CYCLES_DEF - 1);
    end else if (r_cnt != '0) begin
      {r_rem, r_quo} <= div_step(r_rem, r_quo, r_div);
      r_cnt          <= r_cnt - CW'(1);
    end
  end

  assign o_quo = r_neg_q ? -r_quo : r_quo;
  assign o_rem = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/wired_rr_arb.sv
// Round-robin request selector.
//   i_req   : request vector
//   i_ptr   : highest-priority index for this cycle
//   o_grant : one-hot grant (zero when no request)
//   o_idx   : index of the granted request
//   o_valid : at least one request granted
module wired_rr_arb #(
  parameter int unsigned  N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  // Two passes emulate a rotated priority search: indices at or above the
  // pointer first, then the wrapped-around lower indices.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!o_valid && i_req[j] && (j >= 32'(i_ptr))) begin
        o_valid    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = PW'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!o_valid && i_req[j] && (j < 32'(i_ptr))) begin
        o_valid    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/wired_div_arbiter.sv
// Shares one iterative divider between NREQ issue ports.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : drop any accepted, in-flight or buffered op
//   in_valid/in_ready   : per-port request handshake (one grant per cycle)
//   in_a/in_b           : per-port dividend/divisor, port i at [32*i +: 32]
//   in_op               : per-port div_op_t
//   in_tag              : per-port destination tag
//   out_valid/out_ready : result handshake
//   out_data            : quotient (DIV/DIVU) or remainder (MOD/MODU)
//   out_tag/out_port    : tag and originating port of the returning op
// DIV_CYCLES must equal the iteration count of wired_div_simp.
module wired_div_arbiter
  import wired_div_pkg::*;
#(
  parameter int unsigned  NREQ       = 2,
  parameter int unsigned  TAG_W      = 6,
  parameter int unsigned  DIV_CYCLES = DIV_CYCLES_DEF,
  localparam int unsigned PW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NREQ-1:0]         in_valid,
  output logic [NREQ-1:0]         in_ready,
  input  logic [NREQ*32-1:0]      in_a,
  input  logic [NREQ*32-1:0]      in_b,
  input  logic [NREQ*2-1:0]       in_op,
  input  logic [NREQ*TAG_W-1:0]   in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic [PW-1:0]           out_port
);

  localparam int unsigned CW = $clog2(DIV_CYCLES);

  div_state_t       r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_port;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  div_op_t          r_op;
  logic [TAG_W-1:0] r_tag;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [31:0]      r_out_data;

  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_gidx;
  logic             w_gvalid;
  logic             w_accept;
  logic [PW-1:0]    w_ptr_next;
  logic [31:0]      w_a_sel;
  logic [31:0]      w_b_sel;
  logic [1:0]       w_op_sel;
  logic [TAG_W-1:0] w_tag_sel;
  logic             w_rst_n;
  logic             w_start;
  logic [31:0]      w_quo;
  logic [31:0]      w_rem;

  wired_rr_arb #(
    .N (NREQ)
  ) u_arb (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_a_sel   = '0;
    w_b_sel   = '0;
    w_op_sel  = '0;
    w_tag_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_a_sel   = in_a[32*i +: 32];
        w_b_sel   = in_b[32*i +: 32];
        w_op_sel  = in_op[2*i +: 2];
        w_tag_sel = in_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  // Flush and reset both suppress acceptance in the same cycle.
  always_comb begin
    in_ready = '0;
    if ((r_state == IDLE) && !flush && !rst) begin
      in_ready = w_grant;
    end
  end

  assign w_accept   = (r_state == IDLE) && !flush && w_gvalid;
  assign w_ptr_next = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);

  assign w_rst_n = ~rst;
  assign w_start = (r_state == START);

  wired_div_simp u_div (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_start (w_start),
    .i_sign  (r_op[0]),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_quo   (w_quo),
    .o_rem   (w_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_port      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= DIVU;
      r_tag       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      // The core is left running; its next start pulse reloads it.
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a    <= w_a_sel;
            r_b    <= w_b_sel;
            r_op   <= div_op_t'(w_op_sel);
            r_tag  <= w_tag_sel;
            r_port <= w_gidx;
            r_ptr  <= w_ptr_next;
            if (w_b_sel == '0) begin
              // Divide-by-zero: quotient all ones, remainder is the dividend.
              r_out_data  <= w_op_sel[1] ? w_a_sel : 32'hFFFF_FFFF;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= START;
            end
          end
        end
        START: begin
          r_cnt   <= CW'(DIV_CYCLES - 1);
          r_state <= RUN;
        end
        RUN: begin
          if (r_cnt == '0) begin
            r_out_data  <= r_op[1] ? w_rem : w_quo;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_tag;
  assign out_port  = r_port;

endmodule

// File: tb/tb_wired_div_arbiter.sv
module tb_wired_div_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [3:0]  in_op;
  logic [11:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_tag;
  logic [0:0]  out_port;

  always #5 clk = ~clk;

  wired_div_arbiter #(
    .NREQ       (2),
    .TAG_W      (6),
    .DIV_CYCLES (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_port  (out_port)
  );

  int n_vec = 0;
  int n_err = 0;

  // Pending operation per port.
  logic [31:0] pa[2];
  logic [31:0] pb[2];
  logic [1:0]  pop[2];
  logic [5:0]  ptag[2];

  // Reference state: round-robin pointer and expectations of the op in flight.
  logic        m_ptr;
  logic [31:0] exp_data;
  logic [5:0]  exp_tag;
  int          exp_port;
  int          exp_lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural result: plain integer arithmetic plus the defined corner cases.
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [31:0] q;
    logic [31:0] r;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Present the pending ops on the ports in vmask and wait for the grant.
  task automatic send(input logic [1:0] vmask);
    logic g;
    int   t;
    g        = vmask[m_ptr] ? m_ptr : ~m_ptr;
    in_a     = {pa[1], pa[0]};
    in_b     = {pb[1], pb[0]};
    in_op    = {pop[1], pop[0]};
    in_tag   = {ptag[1], ptag[0]};
    in_valid = vmask;
    t = 0;
    @(negedge clk);
    while (in_ready == 2'b00 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("grant", 64'(in_ready), 64'(2'b01 << g));
    exp_port = int'(g);
    exp_data = ref_res(pa[g], pb[g], pop[g]);
    exp_tag  = ptag[g];
    exp_lat  = (pb[g] == 32'd0) ? 1 : 33;
    m_ptr    = ~g;
    @(posedge clk);
    #1;
    in_valid = vmask & ~(2'b01 << g);
  endtask

  // Wait for the result, check it, optionally stall, optionally consume it.
  task automatic collect(input int hold, input bit release_it);
    int lat;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("data", 64'(out_data), 64'(exp_data));
    check("tag", 64'(out_tag), 64'(exp_tag));
    check("port", 64'(out_port), 64'(exp_port));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(out_data), 64'(exp_data));
      check("hold_tag", 64'(out_tag), 64'(exp_tag));
      check("hold_ready", 64'(in_ready), 64'd0);
    end
    if (release_it) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release", 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    int seen;
    int sel;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 2'b11;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_tag    = '0;
    m_ptr     = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pa[p] = '0; pb[p] = '0; pop[p] = '0; ptag[p] = '0;
    end

    // Reset values, with requests pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_port", 64'(out_port), 64'd0);
    in_valid = 2'b00;
    rst      = 1'b0;
    @(posedge clk);
    #1;

    // DIV 100 / 7 on port 0.
    pa[0] = 32'd100; pb[0] = 32'd7; pop[0] = 2'b01; ptag[0] = 6'h2A;
    send(2'b01); collect(0, 1'b1);

    // Signed remainder of -100 by 7 on port 1, unsigned remainder of the same operands on port 0.
    pa[1] = 32'hFFFF_FF9C; pb[1] = 32'd7; pop[1] = 2'b11; ptag[1] = 6'h11;
    send(2'b10); collect(0, 1'b1);
    pa[0] = 32'hFFFF_FF9C; pb[0] = 32'd7; pop[0] = 2'b10; ptag[0] = 6'h05;
    send(2'b01); collect(0, 1'b1);

    // Divide by zero, quotient and remainder.
    pa[0] = 32'd5; pb[0] = 32'd0; pop[0] = 2'b00; ptag[0] = 6'h3F;
    send(2'b01); collect(0, 1'b1);
    pop[0] = 2'b10;
    send(2'b01); collect(0, 1'b1);

    // Signed overflow corner.
    pa[1] = 32'h8000_0000; pb[1] = 32'hFFFF_FFFF; pop[1] = 2'b01; ptag[1] = 6'h21;
    send(2'b10); collect(0, 1'b1);
    pop[1] = 2'b11;
    send(2'b10); collect(0, 1'b1);

    // Both ports requesting: grants must alternate.
    pa[0] = 32'd1000; pb[0] = 32'd9;  pop[0] = 2'b00; ptag[0] = 6'h01;
    pa[1] = 32'hFFFF_FC18; pb[1] = 32'd3; pop[1] = 2'b01; ptag[1] = 6'h02;
    for (int n = 0; n < 4; n++) begin
      send(2'b11); collect(0, 1'b1);
    end

    // Flush mid-RUN, then flush beating a same-cycle request in IDLE.
    pa[0] = 32'd777; pb[0] = 32'd5; pop[0] = 2'b00; ptag[0] = 6'h0F;
    send(2'b01);
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1; out_ready = 1'b1; in_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    check("flush_ready", 64'(in_ready), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 2'b00;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_quiet", 64'(seen), 64'd0);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    pa[1] = 32'd12345; pb[1] = 32'd100; pop[1] = 2'b10; ptag[1] = 6'h33;
    send(2'b10); collect(0, 1'b1);

    // Stall in DONE, then asynchronous reset while the result is held.
    pa[0] = 32'd81; pb[0] = 32'hFFFF_FFFD; pop[0] = 2'b01; ptag[0] = 6'h1C;
    send(2'b01); collect(5, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-RUN.
    pa[1] = 32'd50; pb[1] = 32'd6; pop[1] = 2'b00; ptag[1] = 6'h07;
    send(2'b10);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_run_valid", 64'(out_valid), 64'd0);
    check("arst_run_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 1'b0;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("arst_run_quiet", 64'(seen), 64'd0);
    @(posedge clk);
    #1;

    // Randomized operations against the reference model.
    for (int n = 0; n < 24; n++) begin
      for (int p = 0; p < 2; p++) begin
        pa[p]   = $urandom;
        pb[p]   = $urandom;
        sel     = $urandom_range(0, 7);
        if (sel == 0) pb[p] = 32'd0;
        if (sel == 1) pb[p] = 32'hFFFF_FFFF;
        if (sel == 2) pa[p] = 32'h8000_0000;
        if (sel == 3) pb[p] = 32'($urandom_range(1, 15));
        pop[p]  = 2'($urandom_range(0, 3));
        ptag[p] = 6'($urandom);
      end
      send(2'($urandom_range(1, 3)));
      collect((n % 4 == 0) ? 2 : 0, 1'b1);
    end

    in_valid = 2'b00;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
